// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM with clear sweep.
package dpram_pkg;

    typedef logic [0:0] clr_state_t;

    localparam clr_state_t IDLE  = 1'b0;
    localparam clr_state_t CLEAR = 1'b1;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

endpackage

// File: rtl/dual_port_ram_clr_if.sv
// Access bus of the dual-port RAM: port A read/write, port B read, clear request/status.
interface dual_port_ram_clr_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
);
    logic              clr;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] DI;
    logic              re_a;
    logic [ADDR_W-1:0] DPRA;
    logic              re_b;
    logic [DATA_W-1:0] SPO;
    logic [DATA_W-1:0] DPO;
    logic              spo_vld;
    logic              dpo_vld;

    modport master (
        output clr, we, address, DI, re_a, DPRA, re_b,
        input  busy, SPO, DPO, spo_vld, dpo_vld
    );

    modport slave (
        input  clr, we, address, DI, re_a, DPRA, re_b,
        output busy, SPO, DPO, spo_vld, dpo_vld
    );
endinterface

// File: rtl/dpram_clr_ctrl.sv
// Clear sweep controller: walks every address once, one word per cycle, after reset or clr.
module dpram_clr_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // counter wraps to 0 on the final write, ready for the next sweep
                cnt_d = ADDR_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = cnt_q;
    assign busy     = busy_q;

endmodule

// File: rtl/dual_port_ram_clr.sv
// Dual-port RAM (A: read/write, B: read) with registered read data and a hardware clear sweep.
// Build option: DPRAM_OUTREG_EN adds one more output register stage (read latency 2).
module dual_port_ram_clr
    import dpram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int unsigned       WR_MODE  = READ_FIRST
) (
    input  logic                CLK,
    input  logic                RST_N,
    dual_port_ram_clr_if.slave  bus
);

    localparam int unsigned DEPTH          = 2 ** ADDR_W;
    localparam bit          WRITE_FIRST_EN = (WR_MODE == WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we_c;
    logic [ADDR_W-1:0] clr_addr_c;
    logic              busy_c;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic              rd_a_c, rd_b_c;

    logic [DATA_W-1:0] spo_q, spo_d;
    logic [DATA_W-1:0] dpo_q, dpo_d;
    logic              spo_vld_q, spo_vld_d;
    logic              dpo_vld_q, dpo_vld_d;

    dpram_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (bus.clr),
        .clr_we   (clr_we_c),
        .clr_addr (clr_addr_c),
        .busy     (busy_c)
    );

    // Write port: the sweep owns it while busy, user writes are dropped
    always_comb begin
        wr_en_c   = bus.we & ~busy_c;
        wr_addr_c = bus.address;
        wr_data_c = bus.DI;
        if (clr_we_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_addr_c;
            wr_data_c = INIT_VAL;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Read data capture; same-edge write bypass only in write-first mode
    always_comb begin
        rd_a_c    = bus.re_a & ~busy_c;
        rd_b_c    = bus.re_b & ~busy_c;
        spo_d     = spo_q;
        dpo_d     = dpo_q;
        spo_vld_d = rd_a_c;
        dpo_vld_d = rd_b_c;
        if (rd_a_c) begin
            spo_d = (WRITE_FIRST_EN && bus.we) ? bus.DI : mem[bus.address];
        end
        if (rd_b_c) begin
            dpo_d = (WRITE_FIRST_EN && bus.we && (bus.DPRA == bus.address))
                    ? bus.DI : mem[bus.DPRA];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spo_q     <= '0;
            dpo_q     <= '0;
            spo_vld_q <= 1'b0;
            dpo_vld_q <= 1'b0;
        end else begin
            spo_q     <= spo_d;
            dpo_q     <= dpo_d;
            spo_vld_q <= spo_vld_d;
            dpo_vld_q <= dpo_vld_d;
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [DATA_W-1:0] spo_o_q, dpo_o_q;
    logic              spo_vld_o_q, dpo_vld_o_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spo_o_q     <= '0;
            dpo_o_q     <= '0;
            spo_vld_o_q <= 1'b0;
            dpo_vld_o_q <= 1'b0;
        end else begin
            spo_o_q     <= spo_q;
            dpo_o_q     <= dpo_q;
            spo_vld_o_q <= spo_vld_q;
            dpo_vld_o_q <= dpo_vld_q;
        end
    end

    assign bus.SPO     = spo_o_q;
    assign bus.DPO     = dpo_o_q;
    assign bus.spo_vld = spo_vld_o_q;
    assign bus.dpo_vld = dpo_vld_o_q;
`else
    assign bus.SPO     = spo_q;
    assign bus.DPO     = dpo_q;
    assign bus.spo_vld = spo_vld_q;
    assign bus.dpo_vld = dpo_vld_q;
`endif

    assign bus.busy = busy_c;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Directed bench: a READ_FIRST and a WRITE_FIRST instance driven by the same stimulus.
module tb_dual_port_ram_clr;
    import dpram_pkg::*;

`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk;
    logic        rst_n;
    logic        clr, we, re_a, re_b;
    logic [5:0]  address, DPRA;
    logic [15:0] DI;

    int errors = 0;
    int checks = 0;
    int n;

    dual_port_ram_clr_if #(.DATA_W(16), .ADDR_W(6)) bus0 ();
    dual_port_ram_clr_if #(.DATA_W(16), .ADDR_W(6)) bus1 ();

    assign bus0.clr = clr;  assign bus0.we = we;     assign bus0.address = address;
    assign bus0.DI  = DI;   assign bus0.re_a = re_a; assign bus0.DPRA = DPRA;
    assign bus0.re_b = re_b;
    assign bus1.clr = clr;  assign bus1.we = we;     assign bus1.address = address;
    assign bus1.DI  = DI;   assign bus1.re_a = re_a; assign bus1.DPRA = DPRA;
    assign bus1.re_b = re_b;

    dual_port_ram_clr #(.DATA_W(16), .ADDR_W(6), .INIT_VAL(INIT), .WR_MODE(READ_FIRST))
        dut_rf (.CLK(clk), .RST_N(rst_n), .bus(bus0.slave));
    dual_port_ram_clr #(.DATA_W(16), .ADDR_W(6), .INIT_VAL(INIT), .WR_MODE(WRITE_FIRST))
        dut_wf (.CLK(clk), .RST_N(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [5:0] b);
        address = a; DPRA = b; re_a = 1'b1; re_b = 1'b1;
        tick();
        re_a = 1'b0; re_b = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        address = a; DI = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus0.busy && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b1; clr = 0; we = 0; re_a = 0; re_b = 0;
        address = '0; DPRA = '0; DI = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 16'(bus0.busy), 16'd1);
        chk("rst_spo", bus0.SPO, 16'h0000);
        chk("rst_dpo", bus0.DPO, 16'h0000);
        chk("rst_spo_vld", 16'(bus0.spo_vld), 16'd0);
        chk("rst_dpo_vld", 16'(bus0.dpo_vld), 16'd0);

        // power-up sweep
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(n);
        chk("init_busy_len", 16'(n), 16'd64);
        do_read(6'd0, 6'd0);
        chk("init_spo_0", bus0.SPO, INIT);
        chk("init_dpo_0", bus0.DPO, INIT);
        do_read(6'd37, 6'd37);
        chk("init_spo_37", bus0.SPO, INIT);
        chk("init_dpo_37", bus0.DPO, INIT);
        do_read(6'd63, 6'd63);
        chk("init_spo_63", bus0.SPO, INIT);
        chk("init_dpo_63", bus0.DPO, INIT);

        // basic write then read on both ports
        do_write(6'd5, 16'h1234);
        do_read(6'd5, 6'd5);
        chk("rw_spo", bus0.SPO, 16'h1234);
        chk("rw_dpo", bus0.DPO, 16'h1234);
        chk("rw_spo_vld", 16'(bus0.spo_vld), 16'd1);
        chk("rw_dpo_vld", 16'(bus0.dpo_vld), 16'd1);

        // hold for 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_spo_vld", 16'(bus0.spo_vld), 16'd0);
            chk("hold_dpo_vld", 16'(bus0.dpo_vld), 16'd0);
        end
        chk("hold_spo", bus0.SPO, 16'h1234);
        chk("hold_dpo", bus0.DPO, 16'h1234);

        // same-edge collision on both ports
        do_write(6'd9, 16'h0001);
        we = 1'b1; address = 6'd9; DI = 16'hBEEF; re_a = 1'b1; DPRA = 6'd9; re_b = 1'b1;
        tick();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
        repeat (LAT - 1) tick();
        chk("col_rf_spo", bus0.SPO, 16'h0001);
        chk("col_rf_dpo", bus0.DPO, 16'h0001);
        chk("col_wf_spo", bus1.SPO, 16'hBEEF);
        chk("col_wf_dpo", bus1.DPO, 16'hBEEF);
        do_read(6'd9, 6'd9);
        chk("col_rf_after", bus0.SPO, 16'hBEEF);
        chk("col_wf_after", bus1.DPO, 16'hBEEF);

        // fill memory, then runtime clear with blocked write and ignored clr
        for (int i = 0; i < 64; i++) do_write(6'(i), 16'(i * 7 + 1));
        do_read(6'd3, 6'd40);
        chk("fill_spo_3", bus0.SPO, 16'h0016);
        chk("fill_dpo_40", bus0.DPO, 16'h0119);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = 0;
        while (bus0.busy && n < 200) begin
            n++;
            if (n == 10) begin
                we = 1'b1; address = 6'd3; DI = 16'hFFFF; re_a = 1'b1; re_b = 1'b1; DPRA = 6'd3;
            end else if (n == 11) begin
                we = 1'b0; re_a = 1'b0; re_b = 1'b0;
            end
            clr = (n == 30);
            tick();
            chk("clr_spo_vld", 16'(bus0.spo_vld), 16'd0);
            chk("clr_dpo_vld", 16'(bus0.dpo_vld), 16'd0);
        end
        clr = 1'b0;
        chk("clr_busy_len", 16'(n), 16'd64);
        chk("clr_hold_spo", bus0.SPO, 16'h0016);
        chk("clr_hold_dpo", bus0.DPO, 16'h0119);
        do_read(6'd3, 6'd3);
        chk("clr_spo_3", bus0.SPO, INIT);
        chk("clr_dpo_3", bus0.DPO, INIT);
        do_read(6'd40, 6'd63);
        chk("clr_spo_40", bus0.SPO, INIT);
        chk("clr_dpo_63", bus0.DPO, INIT);

        // reset in the middle of a sweep (counter = 20)
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (20) tick();
        chk("mid_busy_pre", 16'(bus0.busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_spo", bus0.SPO, 16'h0000);
        chk("mid_rst_dpo", bus0.DPO, 16'h0000);
        chk("mid_rst_vld", 16'({bus0.spo_vld, bus0.dpo_vld}), 16'd0);
        chk("mid_rst_busy", 16'(bus0.busy), 16'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(n);
        chk("mid_busy_len", 16'(n), 16'd64);
        do_read(6'd37, 6'd20);
        chk("mid_spo_37", bus0.SPO, INIT);
        chk("mid_dpo_20", bus1.DPO, INIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
